// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA core front end.
//   fetch_state_t : instruction fetch FSM states
//   WORD_W        : datapath / address width
//   PC_STEP       : PC increment per fetched instruction
package musa_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: on a busca pulse, reads one word from instruction
// memory at the current PC, presents it to decode with its address, and
// advances the PC by 4. Supports redirects (pc_load) in every state and a
// bounded wait for the memory acknowledge.
//
// Ports:
//   xclk, rst_n              clock, asynchronous active-low reset
//   busca                    fetch request pulse (honoured in IDLE only)
//   pc_load, pc_target       redirect strobe and address (bits [1:0] ignored)
//   imem_req, imem_addr      memory read request and word-aligned address
//   imem_ack, imem_rdata     memory data strobe and data
//   instr, instr_pc          fetched instruction and its address
//   instr_valid, instr_ready handshake towards decode
//   fetch_busy               high whenever the FSM is not IDLE
//   fetch_err                one-cycle pulse on acknowledge timeout
module instruction_fetch
    import musa_pkg::*;
#(
    parameter int unsigned       XCLK_FREQ   = 122880000,
    parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned       ACK_TIMEOUT = 16
) (
    input  logic              xclk,
    input  logic              rst_n,
    input  logic              busca,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] pc_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_busy,
    output logic              fetch_err
);

    if (XCLK_FREQ == 0 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_param
        $error("instruction_fetch: illegal parameter value");
    end

    // Counter value on the last permitted wait cycle.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n;
    logic [WORD_W-1:0] addr_n, instr_n, ipc_n;
    logic              req_n, valid_n, err_n;
    logic [7:0]        tmo, tmo_n;
    logic [WORD_W-1:0] load_addr;
    logic              timed_out;

    assign load_addr  = pc_target & ~32'd3;
    assign timed_out  = (tmo == TMO_LAST);
    assign fetch_busy = (state != IDLE);

    always_ff @(posedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            tmo         <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr       <= instr_n;
            instr_pc    <= ipc_n;
            instr_valid <= valid_n;
            fetch_err   <= err_n;
            tmo         <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = imem_addr;
        req_n   = imem_req;
        instr_n = instr;
        ipc_n   = instr_pc;
        valid_n = instr_valid;
        err_n   = 1'b0;
        tmo_n   = tmo;

        case (state)
            IDLE: begin
                // Redirect is applied before the fetch so a simultaneous
                // busca reads from the new target.
                if (pc_load) pc_n = load_addr;
                addr_n = pc_n;
                if (busca) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    tmo_n   = '0;
                end
            end

            REQ: begin
                if (pc_load) begin
                    pc_n = load_addr;
                    if (imem_ack) begin
                        // Access completes in the redirect cycle: drop the
                        // data and go straight to the refetch.
                        addr_n = load_addr;
                        tmo_n  = '0;
                    end else if (timed_out) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        err_n   = 1'b1;
                        addr_n  = load_addr;
                    end else begin
                        state_n = DRAIN;
                        tmo_n   = '0;
                    end
                end else if (imem_ack) begin
                    state_n = HOLD;
                    req_n   = 1'b0;
                    instr_n = imem_rdata;
                    ipc_n   = pc;
                    pc_n    = pc + PC_STEP;
                    valid_n = 1'b1;
                end else if (timed_out) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                end else begin
                    tmo_n = tmo + 8'd1;
                end
            end

            DRAIN: begin
                if (pc_load) pc_n = load_addr;
                if (imem_ack) begin
                    state_n = REQ;
                    addr_n  = pc_n;
                    tmo_n   = '0;
                end else if (timed_out) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    addr_n  = pc_n;
                end else begin
                    tmo_n = tmo + 8'd1;
                end
            end

            HOLD: begin
                if (pc_load) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    pc_n    = load_addr;
                    addr_n  = load_addr;
                end else if (instr_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    addr_n  = pc;
                end
            end

            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        xclk = 1'b0;
    logic        rst_n;
    logic        busca, pc_load, imem_ack, instr_ready;
    logic [31:0] pc_target, imem_rdata;
    logic        imem_req, instr_valid, fetch_busy, fetch_err;
    logic [31:0] imem_addr, instr, instr_pc;

    // Second instance exercising the PC wrap from RESET_PC = FFFF_FFFC.
    logic        b_busca, b_ack, b_ready;
    logic [31:0] b_rdata;
    logic        b_req, b_valid, b_busy, b_err;
    logic [31:0] b_addr, b_instr, b_instr_pc;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    logic [63:0] exp_q[$];   // {instr, instr_pc} expected at each new instr_valid
    logic        prev_valid;

    always #5 xclk = ~xclk;

    instruction_fetch #(.ACK_TIMEOUT(6)) dut (
        .xclk(xclk), .rst_n(rst_n), .busca(busca), .pc_load(pc_load),
        .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .xclk(xclk), .rst_n(rst_n), .busca(b_busca), .pc_load(1'b0),
        .pc_target(32'h0), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .instr(b_instr),
        .instr_pc(b_instr_pc), .instr_valid(b_valid), .instr_ready(b_ready),
        .fetch_busy(b_busy), .fetch_err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    // Monitor: every fresh instr_valid must match the next queued expectation.
    always @(negedge xclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= instr_valid;
            if (instr_valid && !prev_valid) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_instr: got %h@%h expected none", instr, instr_pc);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({instr, instr_pc} === e) pass_cnt++;
                    else $display("FAIL instr_scoreboard: got %h@%h expected %h@%h",
                                  instr, instr_pc, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; busca = 0; pc_load = 0; pc_target = '0; imem_ack = 0;
        imem_rdata = '0; instr_ready = 0;
        b_busca = 0; b_ack = 0; b_ready = 0; b_rdata = '0;
        repeat (2) step();

        // Reset values
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_ipc",   instr_pc,             32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_busy",  {31'b0, fetch_busy},  32'd0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);
        rst_n = 1'b1;
        step();

        // Basic fetch, ack two cycles after busca
        busca = 1; step(); busca = 0;
        chk("f1_req",  {31'b0, imem_req},   32'd1);
        chk("f1_addr", imem_addr,           32'd0);
        chk("f1_busy", {31'b0, fetch_busy}, 32'd1);
        step();
        exp_q.push_back({32'h2008_0005, 32'h0});
        imem_ack = 1; imem_rdata = 32'h2008_0005; step(); imem_ack = 0;
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_req_off", {31'b0, imem_req},  32'd0);

        // Decode stalls five cycles; a stray busca must be ignored
        for (int i = 0; i < 5; i++) begin
            busca = (i == 2);
            step();
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, 32'h2008_0005);
        end
        busca = 0;
        instr_ready = 1; step(); instr_ready = 0;
        chk("f1_release", {31'b0, instr_valid}, 32'd0);
        chk("f1_idle",    {31'b0, fetch_busy},  32'd0);
        chk("f1_pc",      imem_addr,            32'd4);

        // Redirect during REQ: first ack discarded, automatic refetch
        busca = 1; step(); busca = 0;
        pc_load = 1; pc_target = 32'h0000_0103; step(); pc_load = 0;
        chk("drain_req",  {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr,         32'd4);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 0;
        chk("refetch_req",   {31'b0, imem_req},    32'd1);
        chk("refetch_addr",  imem_addr,            32'h100);
        chk("refetch_valid", {31'b0, instr_valid}, 32'd0);
        exp_q.push_back({32'h1111_2222, 32'h100});
        imem_ack = 1; imem_rdata = 32'h1111_2222; step(); imem_ack = 0;
        instr_ready = 1; step(); instr_ready = 0;
        chk("refetch_pc", imem_addr, 32'h104);

        // Timeout: no ack for ACK_TIMEOUT (6) cycles
        busca = 1; step(); busca = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tmo_wait_err", {31'b0, fetch_err}, 32'd0);
            chk("tmo_wait_req", {31'b0, imem_req},  32'd1);
        end
        step();
        chk("tmo_err",  {31'b0, fetch_err},  32'd1);
        chk("tmo_req",  {31'b0, imem_req},   32'd0);
        chk("tmo_busy", {31'b0, fetch_busy}, 32'd0);
        chk("tmo_pc",   imem_addr,           32'h104);
        step();
        chk("tmo_pulse", {31'b0, fetch_err}, 32'd0);

        // Stray ack in IDLE is ignored
        imem_ack = 1; imem_rdata = 32'h5555_5555; step(); imem_ack = 0;
        chk("idle_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("idle_ack_busy",  {31'b0, fetch_busy},  32'd0);

        // pc_load with busca in IDLE fetches from the new target
        pc_load = 1; pc_target = 32'h0000_0203; busca = 1; step();
        pc_load = 0; busca = 0;
        chk("ld_idle_addr", imem_addr, 32'h200);
        exp_q.push_back({32'hA5A5_A5A5, 32'h200});
        imem_ack = 1; imem_rdata = 32'hA5A5_A5A5; step(); imem_ack = 0;
        // pc_load in HOLD overrides a simultaneous instr_ready
        pc_load = 1; pc_target = 32'h0000_0042; instr_ready = 1; step();
        pc_load = 0; instr_ready = 0;
        chk("ld_hold_valid", {31'b0, instr_valid}, 32'd0);
        chk("ld_hold_busy",  {31'b0, fetch_busy},  32'd0);
        chk("ld_hold_pc",    imem_addr,            32'h40);

        // Reset while in REQ, then a late ack
        busca = 1; step(); busca = 0;
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        rst_n = 0; #1;
        chk("async_req",  {31'b0, imem_req},   32'd0);
        chk("async_busy", {31'b0, fetch_busy}, 32'd0);
        step(); rst_n = 1;
        imem_ack = 1; imem_rdata = 32'h7777_7777; step(); imem_ack = 0;
        step();
        chk("late_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_instr", instr,                32'd0);
        chk("late_ipc",   instr_pc,             32'd0);
        chk("late_addr",  imem_addr,            32'd0);
        chk("late_busy",  {31'b0, fetch_busy},  32'd0);

        // PC wrap on the second instance
        b_busca = 1; step(); b_busca = 0;
        chk("wrap_addr", b_addr, 32'hFFFF_FFFC);
        b_ack = 1; b_rdata = 32'h0000_0013; step(); b_ack = 0;
        chk("wrap_valid", {31'b0, b_valid}, 32'd1);
        chk("wrap_instr", b_instr,          32'h13);
        chk("wrap_ipc",   b_instr_pc,       32'hFFFF_FFFC);
        b_ready = 1; step(); b_ready = 0;
        chk("wrap_pc", b_addr, 32'h0);

        step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
